// File: rtl/cfg_pkg.sv
// Shared types, constants and sizing helper for the LUT configuration loader.
package cfg_pkg;

    localparam int unsigned CFG_BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone
    } cfg_state_e;

    // Scan chain length for lut_count LUTs of 2^lut_size configuration bits each.
    function automatic int unsigned chain_len(input int unsigned lut_count,
                                              input int unsigned lut_size);
        return lut_count * (32'd1 << lut_size);
    endfunction

endpackage

// File: rtl/cfg_loader_if.sv
// Host-side byte port of the configuration loader: write bytes in, readback bytes out.
interface cfg_loader_if;
    import cfg_pkg::*;

    logic [CFG_BYTE_W-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [CFG_BYTE_W-1:0] rb_data;
    logic                  rb_valid;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  rb_data,
        input  rb_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output rb_data,
        output rb_valid
    );

endinterface

// File: rtl/cfg_rb_packer.sv
// Collects bits leaving the chain tail into readback bytes, first-out bit in the MSB.
module cfg_rb_packer
    import cfg_pkg::*;
(
    input  logic                  prog_clk,
    input  logic                  prog_rst,
    input  logic                  clear,
    input  logic                  sample,
    input  logic                  last,
    input  logic                  tail_bit,
    output logic [CFG_BYTE_W-1:0] rb_data,
    output logic                  rb_valid
);

    logic [CFG_BYTE_W-1:0] sh_q, sh_d;
    logic [CFG_BYTE_W-1:0] rb_data_q, rb_data_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rb_valid_q, rb_valid_d;
    logic [CFG_BYTE_W-1:0] shifted;

    always_comb begin
        shifted    = {sh_q[CFG_BYTE_W-2:0], tail_bit};
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if (clear) begin
            sh_d  = '0;
            cnt_d = '0;
        end else if (sample) begin
            sh_d  = shifted;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7 || last) begin
                // Short final group: stale upper bits are shifted out, zeros fill the bottom.
                rb_data_d  = shifted << (3'd7 - cnt_q);
                rb_valid_d = 1'b1;
                sh_d       = '0;
                cnt_d      = '0;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;

endmodule

// File: rtl/cfg_loader.sv
// Serialises host configuration bytes MSB-first onto the LUT scan chain and
// returns the bits shifted out of the chain tail as readback bytes.
module cfg_loader
    import cfg_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 64
) (
    input  logic        prog_clk,
    input  logic        prog_rst,
    input  logic        start,
    cfg_loader_if.slave host,
    output logic        prog_en,
    output logic        prog_data,
    input  logic        chain_tail,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);

    cfg_state_e            state_q, state_d;
    logic [CNT_W-1:0]      bits_left_q, bits_left_d;
    logic [CFG_BYTE_W-1:0] buf_q, buf_d;
    logic [3:0]            buf_cnt_q, buf_cnt_d;
    logic                  prog_en_q, prog_en_d;
    logic                  prog_data_q, prog_data_d;

    logic                  launch;
    logic                  shift;
    logic                  in_ready;
    logic                  accept;
    logic                  last_sample;
    logic [CFG_BYTE_W-1:0] rb_data;
    logic                  rb_valid;

    always_comb begin
        launch = start && (state_q != StLoad);
        shift  = (state_q == StLoad) && (buf_cnt_q != 4'd0) && (bits_left_q != '0);
        // Accept on empty, or alongside the last buffered bit if the chain still wants more.
        in_ready = (state_q == StLoad) && (bits_left_q != '0) &&
                   ((buf_cnt_q == 4'd0) ||
                    ((buf_cnt_q == 4'd1) && (bits_left_q != CNT_W'(1))));
        accept      = in_ready && host.in_valid;
        last_sample = (state_q == StLoad) && (bits_left_q == '0);
    end

    always_comb begin
        state_d     = state_q;
        bits_left_d = bits_left_q;
        buf_d       = buf_q;
        buf_cnt_d   = buf_cnt_q;
        prog_en_d   = shift;
        prog_data_d = shift & buf_q[CFG_BYTE_W-1];

        unique case (state_q)
            StIdle, StDone: if (start) state_d = StLoad;
            // Leave once the edge consuming the final registered prog_en pulse has passed.
            StLoad:         if (bits_left_q == '0 && prog_en_q) state_d = StDone;
            default:        state_d = StIdle;
        endcase

        if (launch) begin
            bits_left_d = CNT_W'(CHAIN_LEN);
            buf_cnt_d   = 4'd0;
        end else begin
            if (shift) bits_left_d = bits_left_q - CNT_W'(1);
            if (accept) begin
                buf_d     = host.in_data;
                buf_cnt_d = 4'(CFG_BYTE_W);
            end else if (shift) begin
                buf_d     = {buf_q[CFG_BYTE_W-2:0], 1'b0};
                buf_cnt_d = buf_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            state_q     <= StIdle;
            bits_left_q <= '0;
            buf_q       <= '0;
            buf_cnt_q   <= '0;
            prog_en_q   <= 1'b0;
            prog_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bits_left_q <= bits_left_d;
            buf_q       <= buf_d;
            buf_cnt_q   <= buf_cnt_d;
            prog_en_q   <= prog_en_d;
            prog_data_q <= prog_data_d;
        end
    end

    cfg_rb_packer u_rb_packer (
        .prog_clk (prog_clk),
        .prog_rst (prog_rst),
        .clear    (launch),
        .sample   (prog_en_q),
        .last     (last_sample),
        .tail_bit (chain_tail),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

    assign host.in_ready = in_ready;
    assign host.rb_data  = rb_data;
    assign host.rb_valid = rb_valid;
    assign prog_en       = prog_en_q;
    assign prog_data     = prog_data_q;
    assign busy          = (state_q == StLoad);
    assign done          = (state_q == StDone);

endmodule
